// File: rtl/dvs_pkt_pkg.sv
// dvs_pkt_pkg: packet layout constants, packet type and the multicast packet
// builder shared by the DVS event packetizer.
package dvs_pkt_pkg;

  localparam int PKT_W        = 72;
  localparam int HDR_PAR_BIT  = 0;   // odd-parity bit
  localparam int HDR_PL_BIT   = 1;   // payload-present flag
  localparam int HDR_TYPE_LSB = 6;
  localparam int HDR_TYPE_MSB = 7;
  localparam int KEY_LSB      = 8;
  localparam int PL_LSB       = 40;

  localparam logic [1:0] MC_TYPE = 2'b00;

  typedef logic [PKT_W-1:0] pkt_t;

  // Assemble a multicast packet; the parity bit makes total parity odd.
  function automatic pkt_t build_mc_pkt(input logic [31:0] key,
                                        input logic [31:0] payload,
                                        input logic        has_pl);
    pkt_t p;
    p = '0;
    p[HDR_TYPE_MSB:HDR_TYPE_LSB] = MC_TYPE;
    p[HDR_PL_BIT]                = has_pl;
    p[KEY_LSB +: 32]             = key;
    p[PL_LSB +: 32]              = payload;
    p[HDR_PAR_BIT]               = ~(^p);
    return p;
  endfunction

endpackage

// File: rtl/dvs_event_packetizer_if.sv
// dvs_event_packetizer_if: event input handshake plus the per-channel packet
// outputs toward the HSSL interface. master = event source / packet sink,
// slave = the packetizer.
interface dvs_event_packetizer_if #(
  parameter int X_BITS       = 8,
  parameter int Y_BITS       = 8,
  parameter int NUM_CHANNELS = 8,
  parameter int PACKET_BITS  = 72
);
  logic [X_BITS-1:0]                          evt_x_in;
  logic [Y_BITS-1:0]                          evt_y_in;
  logic                                       evt_pol_in;
  logic                                       evt_vld_in;
  logic                                       evt_rdy_out;
  logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0]   tx_pkt_data_out;
  logic [NUM_CHANNELS-1:0]                    tx_pkt_vld_out;
  logic [NUM_CHANNELS-1:0]                    tx_pkt_rdy_in;

  modport master (
    output evt_x_in, evt_y_in, evt_pol_in, evt_vld_in, tx_pkt_rdy_in,
    input  evt_rdy_out, tx_pkt_data_out, tx_pkt_vld_out
  );

  modport slave (
    input  evt_x_in, evt_y_in, evt_pol_in, evt_vld_in, tx_pkt_rdy_in,
    output evt_rdy_out, tx_pkt_data_out, tx_pkt_vld_out
  );
endinterface

// File: rtl/dvs_pkt_fifo.sv
// dvs_pkt_fifo: single-channel first-word-fall-through packet FIFO.
// Pointers carry one extra wrap bit; the head entry is shown as soon as the
// FIFO is non-empty, so a write is visible one cycle later (no bypass).
module dvs_pkt_fifo #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PACKET_BITS = 72
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [PACKET_BITS-1:0] wr_data,
  output logic                   full,
  input  logic                   rd_rdy,
  output logic                   rd_vld,
  output logic [PACKET_BITS-1:0] rd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PACKET_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   empty;
  logic                   push;
  logic                   pop;

  // Flag and pointer update; a push into a full FIFO is refused.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    push     = wr_en && !full;
    pop      = rd_rdy && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    rd_vld   = !empty;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset discards any buffered packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/dvs_event_packetizer.sv
// dvs_event_packetizer: turns DVS address-events into 72-bit SpiNNaker
// multicast packets, steers them by x-region into per-channel FIFOs, and
// counts events discarded while the link is down.
// Optional feature: define DVS_PAYLOAD_TIMESTAMP_EN to attach a 32-bit
// free-running timestamp as packet payload.
module dvs_event_packetizer
  import dvs_pkt_pkg::*;
#(
  parameter int          PACKET_BITS  = 72,
  parameter int          NUM_CHANNELS = 8,
  parameter int          X_BITS       = 8,
  parameter int          Y_BITS       = 8,
  parameter logic [31:0] KEY_BASE     = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dvs_event_packetizer_if.slave   bus,
  input  logic                    handshake_complete_in,
  output logic [15:0]             drop_cnt_out,
  output logic [NUM_CHANNELS-1:0] fifo_full_out
);
  localparam int CH_BITS = $clog2(NUM_CHANNELS);

  logic [CH_BITS-1:0]                       ch;
  logic [31:0]                              key;
  logic [31:0]                              payload;
  logic                                     has_pl;
  logic [PACKET_BITS-1:0]                   pkt;
  logic                                     accept;
  logic                                     drop;
  logic [NUM_CHANNELS-1:0]                  wr_en;
  logic [NUM_CHANNELS-1:0]                  full;
  logic [NUM_CHANNELS-1:0]                  vld;
  logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] data;
  logic                                     evt_rdy;
  logic                                     rst_done_q, rst_done_d;
  logic [15:0]                              drop_cnt_q, drop_cnt_d;

`ifdef DVS_PAYLOAD_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  // Free-running timestamp, wraps naturally.
  always_comb ts_d = ts_q + 32'd1;

  // Timestamp register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  assign payload = ts_q;
  assign has_pl  = 1'b1;
`else
  assign payload = '0;
  assign has_pl  = 1'b0;
`endif

  // Packet formation, input ready, channel steering and drop counting.
  always_comb begin
    ch         = bus.evt_x_in[X_BITS-1 -: CH_BITS];
    key        = KEY_BASE | 32'({bus.evt_y_in, bus.evt_x_in, bus.evt_pol_in});
    pkt        = PACKET_BITS'(build_mc_pkt(key, payload, has_pl));
    evt_rdy    = 1'b0;
    if (rst_done_q) evt_rdy = handshake_complete_in ? !full[ch] : 1'b1;
    accept     = bus.evt_vld_in && evt_rdy;
    drop       = accept && !handshake_complete_in;
    wr_en      = '0;
    if (accept && handshake_complete_in) wr_en[ch] = 1'b1;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    rst_done_d = 1'b1;
  end

  // Drop counter and out-of-reset flag (keeps evt_rdy_out low during reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
      rst_done_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      rst_done_q <= rst_done_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      dvs_pkt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PACKET_BITS(PACKET_BITS)
      ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (wr_en[gi]),
        .wr_data(pkt),
        .full   (full[gi]),
        .rd_rdy (bus.tx_pkt_rdy_in[gi]),
        .rd_vld (vld[gi]),
        .rd_data(data[gi])
      );
    end
  endgenerate

  assign bus.evt_rdy_out     = evt_rdy;
  assign bus.tx_pkt_vld_out  = vld;
  assign bus.tx_pkt_data_out = data;
  assign drop_cnt_out        = drop_cnt_q;
  assign fifo_full_out       = full;
endmodule

// File: tb/tb_dvs_event_packetizer.sv
// Testbench for dvs_event_packetizer: table-driven single-event vectors plus
// hand-written sequences for back-pressure, channel independence, link-down
// dropping/saturation, asynchronous reset and (optionally) timestamp payload.
module tb_dvs_event_packetizer;
  localparam int NCH = 8;
  localparam int PB  = 72;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           link;
  logic [15:0]    drop_cnt;
  logic [NCH-1:0] full_flags;
  logic [31:0]    tb_ts;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dvs_event_packetizer_if #(.X_BITS(8), .Y_BITS(8), .NUM_CHANNELS(NCH), .PACKET_BITS(PB)) bus ();

  dvs_event_packetizer #(
    .PACKET_BITS(PB), .NUM_CHANNELS(NCH), .X_BITS(8), .Y_BITS(8),
    .KEY_BASE(32'h0000_0000), .FIFO_DEPTH(4)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .bus                  (bus),
    .handshake_complete_in(link),
    .drop_cnt_out         (drop_cnt),
    .fifo_full_out        (full_flags)
  );

  // Reference timestamp: 0 in reset, +1 per clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected packet built independently from the event fields.
  function automatic logic [PB-1:0] exp_pkt(input logic [7:0] x, input logic [7:0] y,
                                            input logic pol, input logic [31:0] ts);
    logic [PB-1:0] p;
    int ones;
    p = '0;
    ones = 0;
    p[39:8] = {15'd0, y, x, pol};
`ifdef DVS_PAYLOAD_TIMESTAMP_EN
    p[71:40] = ts;
    p[1] = 1'b1;
`endif
    for (int i = 0; i < PB; i++) ones += int'(p[i]);
    if (ones % 2 == 0) p[0] = 1'b1;
    return p;
  endfunction

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic pol);
    bus.evt_x_in   = x;
    bus.evt_y_in   = y;
    bus.evt_pol_in = pol;
    bus.evt_vld_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        pol;
    int          ch;
    logic [31:0] key;
  } vec_t;

  vec_t vecs [6];
  logic [PB-1:0] expq [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{x: 8'h47, y: 8'h12, pol: 1'b1, ch: 2, key: 32'h0000_248F};
    vecs[1] = '{x: 8'h00, y: 8'h00, pol: 1'b0, ch: 0, key: 32'h0000_0000};
    vecs[2] = '{x: 8'hFF, y: 8'hFF, pol: 1'b1, ch: 7, key: 32'h0001_FFFF};
    vecs[3] = '{x: 8'hA0, y: 8'h03, pol: 1'b0, ch: 5, key: 32'h0000_0740};
    vecs[4] = '{x: 8'h20, y: 8'h80, pol: 1'b1, ch: 1, key: 32'h0001_0041};
    vecs[5] = '{x: 8'hE5, y: 8'h5A, pol: 1'b0, ch: 7, key: 32'h0000_B5CA};

    reset_n = 1'b0;
    link = 1'b1;
    bus.evt_x_in = '0; bus.evt_y_in = '0; bus.evt_pol_in = 1'b0; bus.evt_vld_in = 1'b0;
    bus.tx_pkt_rdy_in = '1;

    // Reset state
    #13;
    chk("rst_evt_rdy", PB'(bus.evt_rdy_out), '0);
    chk("rst_vld", PB'(bus.tx_pkt_vld_out), '0);
    chk("rst_drop", PB'(drop_cnt), '0);
    chk("rst_full", PB'(full_flags), '0);
    for (int c = 0; c < NCH; c++) chk("rst_data", bus.tx_pkt_data_out[c], '0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); @(negedge clk);

    // Table-driven single events, link up, all channels ready
    for (int i = 0; i < 6; i++) begin
      logic [PB-1:0] e;
      @(negedge clk);
      drive(vecs[i].x, vecs[i].y, vecs[i].pol);
      e = exp_pkt(vecs[i].x, vecs[i].y, vecs[i].pol, tb_ts);
      #1 chk("vec_evt_rdy", PB'(bus.evt_rdy_out), PB'(1));
      @(negedge clk);
      bus.evt_vld_in = 1'b0;
      chk("vec_vld", PB'(bus.tx_pkt_vld_out), PB'(8'(1) << vecs[i].ch));
      chk("vec_pkt", bus.tx_pkt_data_out[vecs[i].ch], e);
      chk("vec_key", PB'(bus.tx_pkt_data_out[vecs[i].ch][39:8]), PB'(vecs[i].key));
      $display("txn vec %0d x=%h y=%h pol=%b ch=%0d pkt=%h", i, vecs[i].x, vecs[i].y,
               vecs[i].pol, vecs[i].ch, bus.tx_pkt_data_out[vecs[i].ch]);
`ifndef DVS_PAYLOAD_TIMESTAMP_EN
      if (i == 0) chk("vec0_hdr", PB'(bus.tx_pkt_data_out[2][7:0]), PB'(8'h00));
`endif
      @(negedge clk);
      chk("vec_drained", PB'(bus.tx_pkt_vld_out), '0);
    end

    // Back-pressure on channel 5: four fit, fifth waits, order preserved
    bus.tx_pkt_rdy_in = 8'hDF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(8'hA0, 8'(i), 1'b0);
      expq[i] = exp_pkt(8'hA0, 8'(i), 1'b0, tb_ts);
      #1 chk("bp_evt_rdy", PB'(bus.evt_rdy_out), PB'(1));
      $display("txn bp write %0d", i);
    end
    @(negedge clk);
    drive(8'hA0, 8'd4, 1'b0);
    #1;
    chk("bp_full", PB'(full_flags[5]), PB'(1));
    chk("bp_rdy_low", PB'(bus.evt_rdy_out), '0);
    chk("bp_head0", bus.tx_pkt_data_out[5], expq[0]);
    @(negedge clk);
    chk("bp_rdy_hold", PB'(bus.evt_rdy_out), '0);
    bus.tx_pkt_rdy_in = '1;
    @(negedge clk);
    chk("bp_full_drop", PB'(full_flags[5]), '0);
    chk("bp_rdy_back", PB'(bus.evt_rdy_out), PB'(1));
    chk("bp_head1", bus.tx_pkt_data_out[5], expq[1]);
    expq[4] = exp_pkt(8'hA0, 8'd4, 1'b0, tb_ts);
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("bp_head2", bus.tx_pkt_data_out[5], expq[2]);
    @(negedge clk);
    chk("bp_head3", bus.tx_pkt_data_out[5], expq[3]);
    @(negedge clk);
    chk("bp_head4", bus.tx_pkt_data_out[5], expq[4]);
    @(negedge clk);
    chk("bp_empty", PB'(bus.tx_pkt_vld_out[5]), '0);
    $display("txn bp drained");

    // Stalled channel 5 does not block channel 0
    bus.tx_pkt_rdy_in = 8'hDF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(8'hA0, 8'(8'h10 + i), 1'b0);
    end
    for (int j = 0; j < 6; j++) begin
      logic [PB-1:0] prev;
      @(negedge clk);
      if (j > 0) begin
        chk("ind_vld0", PB'(bus.tx_pkt_vld_out[0]), PB'(1));
        chk("ind_pkt0", bus.tx_pkt_data_out[0], prev);
      end
      chk("ind_full5", PB'(full_flags[5]), PB'(1));
      drive(8'h00, 8'(j), 1'b1);
      prev = exp_pkt(8'h00, 8'(j), 1'b1, tb_ts);
      #1 chk("ind_evt_rdy", PB'(bus.evt_rdy_out), PB'(1));
      $display("txn ind ch0 event %0d", j);
    end
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("ind_last0", PB'(bus.tx_pkt_vld_out[0]), PB'(1));
    bus.tx_pkt_rdy_in = '1;
    repeat (6) @(negedge clk);
    chk("ind_all_empty", PB'(bus.tx_pkt_vld_out), '0);

    // Link down: events dropped and counted
    link = 1'b0;
    chk("drop_start", PB'(drop_cnt), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8'(8'h40 * i), 8'h01, 1'b0);
      #1 chk("drop_evt_rdy", PB'(bus.evt_rdy_out), PB'(1));
    end
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("drop_no_vld", PB'(bus.tx_pkt_vld_out), '0);
    chk("drop_cnt3", PB'(drop_cnt), PB'(16'd3));
    $display("txn drop count=%0d", drop_cnt);

    // Saturation from a preloaded count
    force dut.drop_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_cnt_q;
    #1 chk("sat_preload", PB'(drop_cnt), PB'(16'hFFFE));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(8'h60, 8'(i), 1'b1);
    end
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("sat_cnt", PB'(drop_cnt), PB'(16'hFFFF));
    $display("txn saturate count=%h", drop_cnt);

    // Link comes up in the same cycle as the transfer
    begin
      logic [PB-1:0] e;
      @(negedge clk);
      link = 1'b1;
      drive(8'h80, 8'h33, 1'b1);
      e = exp_pkt(8'h80, 8'h33, 1'b1, tb_ts);
      @(negedge clk);
      bus.evt_vld_in = 1'b0;
      chk("linkup_pkt", bus.tx_pkt_data_out[4], e);
      chk("linkup_drop", PB'(drop_cnt), PB'(16'hFFFF));
      $display("txn link-up event ch4");
    end
    @(negedge clk);

    // Asynchronous reset mid-stream empties the FIFOs
    bus.tx_pkt_rdy_in = 8'hFD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8'h20, 8'(i), 1'b0);
    end
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("ar_pre_vld1", PB'(bus.tx_pkt_vld_out[1]), PB'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("ar_vld", PB'(bus.tx_pkt_vld_out), '0);
    chk("ar_data1", bus.tx_pkt_data_out[1], '0);
    chk("ar_drop", PB'(drop_cnt), '0);
    chk("ar_evt_rdy", PB'(bus.evt_rdy_out), '0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_stale", PB'(bus.tx_pkt_vld_out), '0);
    end
    $display("txn async reset done");
    bus.tx_pkt_rdy_in = '1;

`ifdef DVS_PAYLOAD_TIMESTAMP_EN
    // Timestamp payload for an event accepted 100 cycles after reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    drive(8'h47, 8'h12, 1'b1);
    @(negedge clk);
    bus.evt_vld_in = 1'b0;
    chk("ts_payload", PB'(bus.tx_pkt_data_out[2][71:40]), PB'(32'd100));
    chk("ts_hdr_pl", PB'(bus.tx_pkt_data_out[2][1]), PB'(1));
    chk("ts_parity", PB'(^bus.tx_pkt_data_out[2]), PB'(1));
    $display("txn timestamp pkt=%h", bus.tx_pkt_data_out[2]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
